// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, read-only cache tag controller with a single outstanding fill.
//
// Ports:
//   clk, rst_n            - single rising-edge clock, asynchronous active-low reset
//   addr, addr_valid      - CPU lookup request; accepted when addr_valid && addr_ready
//   addr_ready            - high only in IDLE while flush is low
//   flush                 - invalidate every line (honoured only in IDLE)
//   resp_valid, resp_hit  - one-cycle lookup result, resp_hit qualified by resp_valid
//   mem_req, mem_addr     - line fill request and its block-aligned address
//   mem_ack               - fill complete (ignored outside FILL)
//   hit_count, miss_count - saturating statistics counters
//
// Build option: define CACHE_STATS_EN to implement the counters; without it both
// counters are tied to zero.
module cache_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic {StIdle, StFill} state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q [LINES];
  logic [INDEX_BITS-1:0]   req_idx_q, req_idx_d;
  logic [TAG_W-1:0]        req_tag_q, req_tag_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_hit_q, resp_hit_d;
  logic                    fill_done;

  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        tag;
  logic                    lookup_hit;
  logic                    unused_offset;

  assign idx           = addr[OFFSET_BITS +: INDEX_BITS];
  assign tag           = addr[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^addr[OFFSET_BITS-1:0];
  assign lookup_hit    = valid_q[idx] && (tag_q[idx] == tag);

  assign addr_ready = (state_q == StIdle) && !flush;
  // Derived from state so an asynchronous reset drops it immediately.
  assign mem_req    = (state_q == StFill);
  assign mem_addr   = mem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    req_idx_d    = req_idx_q;
    req_tag_d    = req_tag_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    fill_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          valid_d = '0;
        end else if (addr_valid) begin
          if (lookup_hit) begin
            resp_valid_d = 1'b1;
            resp_hit_d   = 1'b1;
          end else begin
            req_idx_d  = idx;
            req_tag_d  = tag;
            mem_addr_d = {tag, idx, {OFFSET_BITS{1'b0}}};
            state_d    = StFill;
          end
        end
      end
      StFill: begin
        if (mem_ack) begin
          fill_done          = 1'b1;
          valid_d[req_idx_q] = 1'b1;
          resp_valid_d       = 1'b1;
          state_d            = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      req_idx_q    <= '0;
      req_tag_q    <= '0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      req_idx_q    <= req_idx_d;
      req_tag_q    <= req_tag_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
    end
  end

  // Tag contents need no reset: every read is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[req_idx_q] <= req_tag_q;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Counters move on the same edge that raises resp_valid, so they already
  // include the response being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (resp_valid_d) begin
      if (resp_hit_d) begin
        if (hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, address width matching the trace-driven CPU address bus.
REQ-002 SHALL have parameter INDEX_BITS, default 4, line index width (16 lines).
REQ-003 SHALL have parameter OFFSET_BITS, default 2, byte offset width (4-byte blocks); tag width TAG_W = ADDR_W-INDEX_BITS-OFFSET_BITS (default 5).
REQ-004 SHALL have ports: clk in 1, single clock, all state on rising edge.
REQ-005 SHALL have ports: rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: addr in ADDR_W, CPU request address.
REQ-007 SHALL have ports: addr_valid in 1, addr holds a request this cycle.
REQ-008 SHALL have ports: addr_ready out 1, request accepted when addr_valid and addr_ready are both high.
REQ-009 SHALL have ports: flush in 1, invalidate all lines.
REQ-010 SHALL have ports: resp_valid out 1, one-cycle pulse, a lookup completed.
REQ-011 SHALL have ports: resp_hit out 1, qualified by resp_valid, 1=hit, 0=miss.
REQ-012 SHALL have ports: mem_req out 1, line fill request to backing memory.
REQ-013 SHALL have ports: mem_addr out ADDR_W, block-aligned fill address, offset bits zero.
REQ-014 SHALL have ports: mem_ack in 1, backing memory fill complete.
REQ-015 SHALL have ports: hit_count out 32 and miss_count out 32, statistics counters.

Function
REQ-016 SHALL be a direct-mapped tag store: per line one valid bit and one TAG_W tag; index = addr[OFFSET_BITS +: INDEX_BITS], tag = addr[ADDR_W-1 -: TAG_W].
REQ-017 SHALL implement FSM states IDLE and FILL; addr_ready = 1 only in IDLE with flush low.
REQ-018 SHALL, on acceptance in IDLE with valid line and matching tag, pulse resp_valid with resp_hit=1 on the next cycle and remain in IDLE (hit latency 1, back-to-back hits every cycle).
REQ-019 SHALL, on acceptance that misses, latch the request, enter FILL next cycle, assert mem_req with mem_addr = {tag,index,OFFSET_BITS'b0}, and hold both stable until mem_ack is sampled high.
REQ-020 SHALL, on mem_ack in FILL, deassert mem_req next cycle, write tag and set valid for the latched index, pulse resp_valid with resp_hit=0, and return to IDLE; mem_ack outside FILL SHALL be ignored.
REQ-021 SHALL accept mem_ack in the first FILL cycle (minimum miss latency 2 cycles from acceptance to resp_valid).
REQ-022 SHALL, with flush high in IDLE, clear all valid bits in one cycle and not accept addr that cycle; flush during FILL SHALL be ignored.
REQ-023 SHALL increment hit_count on each hit response and miss_count on each miss response; both saturate at 32'hFFFF_FFFF.
REQ-024 SHALL, on a miss to an index holding a different valid tag, overwrite that line (no writeback, read-only model).

Reset
REQ-025 SHALL, on rst_n low, immediately enter IDLE, clear all valid bits, and drive resp_valid=0, resp_hit=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0; addr_ready=1 after release.
REQ-026 SHALL, on reset during FILL, abandon the fill without updating any line and produce no response.

Configuration
REQ-027 SHALL, with macro CACHE_STATS_EN defined, implement the counters per REQ-023.
REQ-028 SHALL, without CACHE_STATS_EN, tie hit_count and miss_count to 0 and synthesise no counter logic; all other behaviour unchanged.

Verification
REQ-029 SHALL cover cold miss: after reset, addr=11'h0A4 valid -> mem_req=1, mem_addr=11'h0A4; mem_ack after 3 cycles -> resp_valid, resp_hit=0, miss_count=1.
REQ-030 SHALL cover repeat hit: after REQ-029, addr=11'h0A7 -> resp_valid next cycle, resp_hit=1, no mem_req, hit_count=1.
REQ-031 SHALL cover conflict: addr=11'h0A4 then 11'h4A4 (same index 9, tag 0x02 vs 0x12) -> miss, refill; then 11'h0A4 -> miss again.
REQ-032 SHALL cover flush: after fill of 11'h0A4, pulse flush with addr_valid high -> addr_ready=0 that cycle; next access to 11'h0A4 -> miss.
REQ-033 SHALL cover reset mid-fill: drop rst_n while mem_req=1 -> mem_req=0 immediately, counters 0, no resp_valid; 11'h0A4 misses after release.
REQ-034 SHALL cover streaming: 20 back-to-back accesses to 11'h000..11'h013 with zero-latency mem_ack -> 5 misses, 15 hits (CACHE_STATS_EN defined), counters 0 when undefined.
